rdback_serializer: RTL and testbench

- Drains the 256-bit (4*DQ_WIDTH) read-back FIFO at the softMC top-level output and streams each entry as a sequence of narrower words to the host transmit channel over a valid/ready handshake.
- Sits between the softMC read-back interface (rdback_fifo_empty / rdback_fifo_rden / rdback_data) and the host link TX path.
- Provides backpressure toward the host, in-order word delivery, and a per-entry last marker.

---
 rtl/rdback_serializer_pkg.sv | 19 +
 rtl/rdback_serializer_if.sv | 28 ++
 rtl/rdback_serializer_shift_out_reg.sv | 43 ++++
 rtl/rdback_serializer.sv | 127 ++++++++++++
 tb/tb_rdback_serializer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdback_serializer_pkg.sv
// Shared encodings and sizing helpers for the read-back serializer.
package rdback_serializer_pkg;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_LOAD = 2'd1,
    SER_SEND = 2'd2
  } ser_state_t;

  // Number of host words carried by one FIFO entry.
  function automatic int ser_num_words(input int entry_width, input int out_width);
    return entry_width / out_width;
  endfunction

  function automatic int ser_idx_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/rdback_serializer_if.sv
// Host transmit channel: one word per cycle under a valid/ready handshake.
interface rdback_serializer_if #(
  parameter int OUT_WIDTH = 32
) ();

  // A word moves when tx_valid & tx_ready at a clock edge. Once tx_valid rises
  // it stays high, with tx_data/tx_last frozen, until that transfer happens;
  // tx_valid never depends combinationally on tx_ready.
  logic [OUT_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/rdback_serializer_shift_out_reg.sv
// Parallel-load register that presents one OUT_WIDTH word at a time, LSW first,
// and flags when the final word of the entry is on the output.
module rdback_serializer_shift_out_reg
  import rdback_serializer_pkg::*;
#(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  load_data,
  input  logic                 shift,
  output logic [OUT_WIDTH-1:0] word,
  output logic                 last
);

  localparam int NUM_WORDS = ser_num_words(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W     = ser_idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IN_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]    idx;

  // Load wins over shift so a back-to-back entry never inherits a stale index.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_data;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg >> OUT_WIDTH;
      idx   <= idx + IDX_ONE;
    end
  end

  assign word = shreg[OUT_WIDTH-1:0];
  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/rdback_serializer.sv
// Drains the softMC read-back FIFO and streams each 4*DQ_WIDTH entry to the
// host as OUT_WIDTH words, LSW first, with tx_last on the final word.
module rdback_serializer
  import rdback_serializer_pkg::*;
#(
  parameter int TCQ       = 100,
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_data,
  rdback_serializer_if.master     tx,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output ser_state_t              dbg_state
);

  localparam int ENTRY_WIDTH = 4 * DQ_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if ((ENTRY_WIDTH % OUT_WIDTH) != 0) begin : g_bad_out_width
    $error("rdback_serializer: 4*DQ_WIDTH must be a multiple of OUT_WIDTH");
  end

  if (TCQ < 0) begin : g_bad_tcq
    $error("rdback_serializer: TCQ must not be negative");
  end

  ser_state_t state;
  ser_state_t state_nxt;

  logic                 load;
  logic                 shift;
  logic                 final_accept;
  logic                 rden;
  logic                 word_last;
  logic [OUT_WIDTH-1:0] word;

  rdback_serializer_shift_out_reg #(
    .IN_WIDTH  (ENTRY_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (rdback_data),
    .shift     (shift),
    .word      (word),
    .last      (word_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SER_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The FIFO is non-FWFT: a pop in cycle t presents dout during LOAD at t+1.
  // After the final word is accepted a pending entry is popped in the same
  // cycle, so steady-state throughput is one entry per NUM_WORDS+1 cycles.
  always_comb begin
    state_nxt    = state;
    rden         = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    final_accept = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!rdback_fifo_empty) begin
          rden      = 1'b1;
          state_nxt = SER_LOAD;
        end
      end
      SER_LOAD: begin
        load      = 1'b1;
        state_nxt = SER_SEND;
      end
      SER_SEND: begin
        if (tx.tx_ready) begin
          if (word_last) begin
            final_accept = 1'b1;
            if (!rdback_fifo_empty) begin
              rden      = 1'b1;
              state_nxt = SER_LOAD;
            end else begin
              state_nxt = SER_IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = SER_IDLE;
      end
    endcase
    // A pop taken during reset would lose an entry the restarted FSM never sees.
    if (rst) begin
      rden = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (final_accept) begin
      beat_cnt <= beat_cnt + CNT_ONE;
    end
  end

  assign rdback_fifo_rden = rden;

  // Data and last are forced to zero outside SEND so idle outputs are clean.
  assign tx.tx_valid = (state == SER_SEND);
  assign tx.tx_data  = (state == SER_SEND) ? word : '0;
  assign tx.tx_last  = (state == SER_SEND) && word_last;

  assign busy      = (state != SER_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_rdback_serializer.sv
// Directed bench for rdback_serializer: FIFO model, host sink, and a word
// scoreboard, with immediate assertions at every comparison.
module tb_rdback_serializer;
  import rdback_serializer_pkg::*;

  localparam int DQ_WIDTH  = 64;
  localparam int OUT_WIDTH = 32;
  localparam int CNT_WIDTH = 4;
  localparam int ENTRY_W   = 4 * DQ_WIDTH;
  localparam int N         = ENTRY_W / OUT_WIDTH;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdback_fifo_empty;
  logic                 rdback_fifo_rden;
  logic [ENTRY_W-1:0]   rdback_data;
  logic                 busy;
  logic [CNT_WIDTH-1:0] beat_cnt;
  ser_state_t           dbg_state;

  always #5 clk = ~clk;

  rdback_serializer_if #(.OUT_WIDTH(OUT_WIDTH)) tx_if ();

  rdback_serializer #(
    .TCQ       (100),
    .DQ_WIDTH  (DQ_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdback_fifo_empty (rdback_fifo_empty),
    .rdback_fifo_rden  (rdback_fifo_rden),
    .rdback_data       (rdback_data),
    .tx                (tx_if.master),
    .busy              (busy),
    .beat_cnt          (beat_cnt),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [ENTRY_W-1:0]   fifo_q[$];
  logic [OUT_WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int sb_idx;
  int rden_cnt;
  int cyc;
  int t0;
  int last_acc_cyc;
  logic                 stall_pend;
  logic [OUT_WIDTH-1:0] stall_data;
  logic                 stall_last;
  logic                 any_rden, any_valid, any_busy;
  bit                   ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [ENTRY_W-1:0] obs,
                       input logic [ENTRY_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word k of entry e is {e[15:0], k[15:0]}; entry 0 therefore has word k = k.
  function automatic logic [ENTRY_W-1:0] make_entry(input int e);
    logic [ENTRY_W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'((e << 16) | k);
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_entry(input int e);
    logic [ENTRY_W-1:0] v;
    v = make_entry(e);
    fifo_q.push_back(v);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(v[k*OUT_WIDTH +: OUT_WIDTH]);
    end
    rdback_fifo_empty = 1'b0;
  endtask

  // Called at a negedge: samples the cycle's handshake, crosses one posedge,
  // models the non-FWFT FIFO pop, then returns at the following negedge.
  task automatic step();
    logic                 pop;
    logic                 acc;
    logic [OUT_WIDTH-1:0] w;
    logic                 l;
    #1;
    pop = rdback_fifo_rden;
    acc = tx_if.tx_valid && tx_if.tx_ready && !rst;
    w   = tx_if.tx_data;
    l   = tx_if.tx_last;
    if (stall_pend) begin
      check("stall_valid", tx_if.tx_valid, 1'b1);
      check("stall_data", w, stall_data);
      check("stall_last", l, stall_last);
    end
    stall_pend = tx_if.tx_valid && !tx_if.tx_ready && !rst;
    stall_data = w;
    stall_last = l;
    if (pop) begin
      rden_cnt++;
      check("rden_not_empty", rdback_fifo_empty, 1'b0);
      if (tx_if.tx_valid) check("rden_on_last_accept", {tx_if.tx_ready, l}, 2'b11);
    end
    if (acc) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", exp_q.size(), 1);
      end else begin
        check("sb_word", w, exp_q.pop_front());
        check("sb_last", l, (sb_idx == N - 1));
        sb_idx = (sb_idx == N - 1) ? 0 : sb_idx + 1;
        if (l) last_acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo_q.size() > 0) rdback_data = fifo_q.pop_front();
    rdback_fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) step();
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst               = 1'b1;
    rdback_fifo_empty = 1'b1;
    rdback_data       = '0;
    tx_if.tx_ready    = 1'b0;
    sb_idx            = 0;
    rden_cnt          = 0;
    cyc               = 0;
    t0                = 0;
    last_acc_cyc      = 0;
    stall_pend        = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_valid", tx_if.tx_valid, 1'b0);
    check("rst_last", tx_if.tx_last, 1'b0);
    check("rst_data", tx_if.tx_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_rden", rdback_fifo_rden, 1'b0);
    check("rst_state", dbg_state, SER_IDLE);
    rst = 1'b0;
    step();

    // single entry, ready held high
    tx_if.tx_ready = 1'b1;
    rden_cnt = 0;
    push_entry(0);
    t0 = cyc;
    step();
    check("t1_load_valid", tx_if.tx_valid, 1'b0);
    check("t1_load_state", dbg_state, SER_LOAD);
    check("t1_load_busy", busy, 1'b1);
    step();
    for (int k = 0; k < N; k++) begin
      check("t1_valid", tx_if.tx_valid, 1'b1);
      check("t1_data", tx_if.tx_data, k);
      check("t1_last", tx_if.tx_last, (k == N - 1));
      step();
    end
    check("t1_last_cycle", last_acc_cyc - t0, N + 1);
    check("t1_rden_cnt", rden_cnt, 1);
    check("t1_beat_cnt", beat_cnt, 1);
    check("t1_busy_done", busy, 1'b0);
    check("t1_valid_done", tx_if.tx_valid, 1'b0);

    // backpressure, ready pattern 1,0,0,1
    rden_cnt = 0;
    push_entry(1);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      tx_if.tx_ready = ready_pat[i % 4];
      step();
    end
    check("t2_drained", exp_q.size(), 0);
    check("t2_rden_cnt", rden_cnt, 1);
    check("t2_beat_cnt", beat_cnt, 2);
    check("t2_busy_done", busy, 1'b0);

    // back-to-back: three preloaded entries
    tx_if.tx_ready = 1'b1;
    rden_cnt = 0;
    push_entry(2);
    push_entry(3);
    push_entry(4);
    t0 = cyc;
    drain("t3_drained", 100);
    check("t3_last_cycle", last_acc_cyc - t0, 3 * (N + 1));
    check("t3_rden_cnt", rden_cnt, 3);
    check("t3_beat_cnt", beat_cnt, 5);

    // empty guard
    rden_cnt  = 0;
    any_rden  = 1'b0;
    any_valid = 1'b0;
    any_busy  = 1'b0;
    repeat (100) begin
      any_rden  = any_rden | rdback_fifo_rden;
      any_valid = any_valid | tx_if.tx_valid;
      any_busy  = any_busy | busy;
      step();
    end
    check("t4_rden", any_rden, 1'b0);
    check("t4_rden_cnt", rden_cnt, 0);
    check("t4_valid", any_valid, 1'b0);
    check("t4_busy", any_busy, 1'b0);

    // reset mid-entry after word 3, with another entry waiting
    rden_cnt = 0;
    push_entry(5);
    for (int i = 0; i < 20 && sb_idx != 4; i++) step();
    check("t5_words_before_rst", sb_idx, 4);
    push_entry(6);
    rst = 1'b1;
    #1;
    check("t5_rst_cycle_rden", rdback_fifo_rden, 1'b0);
    step();
    check("t5_valid", tx_if.tx_valid, 1'b0);
    check("t5_last", tx_if.tx_last, 1'b0);
    check("t5_data", tx_if.tx_data, 0);
    check("t5_busy", busy, 1'b0);
    check("t5_beat_cnt", beat_cnt, 0);
    check("t5_state", dbg_state, SER_IDLE);
    check("t5_no_pop_in_rst", rden_cnt, 1);
    repeat (N - 4) void'(exp_q.pop_front());
    sb_idx = 0;
    rst = 1'b0;
    drain("t5_drained", 50);
    check("t5_beat_after", beat_cnt, 1);
    check("t5_rden_cnt", rden_cnt, 2);

    // counter wrap with a 4-bit counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_idx = 0;
    rden_cnt = 0;
    for (int e = 0; e < 16; e++) push_entry(7 + e);
    drain("t6_drained_16", 16 * (N + 1) + 20);
    check("t6_beat_wrap0", beat_cnt, 0);
    push_entry(23);
    drain("t6_drained_17", 30);
    check("t6_beat_wrap1", beat_cnt, 1);
    check("t6_rden_cnt", rden_cnt, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
